seg7_scan_driver: RTL and testbench

Hardware time-multiplexed driver for the board's 4-digit seven-segment display. It consumes the 16-bit hex value that the pipeline stores into the display register and drives the same `leds`/`an` pins the register file currently drives in software. Each load is captured into a shadow register and applied only at a frame boundary, so a displayed frame never mixes old and new digits. The driver scans the digits with a prescaled refresh counter and decodes each nibble to segments.

---
 rtl/display_pkg.sv | 44 ++++
 rtl/seg7_decode.sv | 39 +++
 rtl/seg7_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the four-digit seven-segment scan driver.
//   - DIGITS       : number of multiplexed digits on the board (fixed)
//   - SEG_0..SEG_F : segment patterns, bit 0 = segment a ... bit 6 = segment g,
//                    active-high
//   - an_onehot()  : digit index -> one-hot anode enable
// ----------------------------------------------------------------------------
package display_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Anode enable for a digit index. Always exactly one bit set, so the
    // display can never light two digits at once.
    function automatic logic [3:0] an_onehot(input logic [1:0] digit);
        logic [3:0] onehot;
        case (digit)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
// Purely combinational hex nibble to seven-segment pattern decoder.
// Ports:
//   i_nibble [3:0] : hex digit to display
//   o_seg    [6:0] : segment pattern, active-high, o_seg[0]=a ... o_seg[6]=g
// ----------------------------------------------------------------------------
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Nibble to segment lookup.
    always_comb begin
        o_seg = 7'h00;
        case (i_nibble)
            4'h0:    o_seg = SEG_0;
            4'h1:    o_seg = SEG_1;
            4'h2:    o_seg = SEG_2;
            4'h3:    o_seg = SEG_3;
            4'h4:    o_seg = SEG_4;
            4'h5:    o_seg = SEG_5;
            4'h6:    o_seg = SEG_6;
            4'h7:    o_seg = SEG_7;
            4'h8:    o_seg = SEG_8;
            4'h9:    o_seg = SEG_9;
            4'hA:    o_seg = SEG_A;
            4'hB:    o_seg = SEG_B;
            4'hC:    o_seg = SEG_C;
            4'hD:    o_seg = SEG_D;
            4'hE:    o_seg = SEG_E;
            4'hF:    o_seg = SEG_F;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a four-digit seven-segment display. A loaded
// value is held in a shadow register and only becomes visible at a frame
// boundary, so a frame never mixes digits of two different values.
//
// Parameters:
//   CLK_DIV : clock cycles each digit stays lit (>= 2)
// Ports:
//   clk          : system clock
//   rst          : asynchronous reset, active-high
//   load         : one-cycle strobe, captures value
//   value [15:0] : nibble i is shown on digit i (digit 0 rightmost)
//   lzs          : leading-zero suppression enable
//   blank_mask[3:0] : bit i forces digit i dark
//   leds  [6:0]  : segment drive, active-high (registered)
//   an    [3:0]  : one-hot digit enable, active-high (registered)
//   frame_done   : one-cycle pulse after the digit-3 slot ends (registered)
// ----------------------------------------------------------------------------
module seg7_scan_driver
    import display_pkg::*;
#(
    parameter int CLK_DIV = 50000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        lzs,
    input  logic [3:0]  blank_mask,
    output logic [6:0]  leds,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [1:0]       DIGIT_LAST = 2'(DIGITS - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_digit;
    logic [15:0]      r_shadow;
    logic [15:0]      r_active;
    logic             r_pending;
    logic [6:0]       r_leds;
    logic [3:0]       r_an;
    logic             r_frame_done;

    logic             w_tick;
    logic             w_boundary;
    logic [3:0]       w_nibble;
    logic [6:0]       w_seg;
    logic             w_lz_dark;
    logic             w_dark;

    assign w_tick     = (r_div_cnt == DIV_LAST);
    assign w_boundary = w_tick && (r_digit == DIGIT_LAST);

    // Prescaler and digit scan counter; the digit wraps to 0 at the boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_digit   <= 2'd0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_digit   <= w_boundary ? 2'd0 : r_digit + 2'd1;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Shadow/active value handling. A load coinciding with the boundary goes
    // straight to the active register so it shows in the very next frame;
    // otherwise the latest load waits in the shadow until the boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= 16'h0000;
            r_active  <= 16'h0000;
            r_pending <= 1'b0;
        end else if (load && w_boundary) begin
            r_shadow  <= value;
            r_active  <= value;
            r_pending <= 1'b0;
        end else if (load) begin
            r_shadow  <= value;
            r_pending <= 1'b1;
        end else if (w_boundary && r_pending) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
        end else begin
            r_pending <= r_pending;
        end
    end

    // Select the nibble of the digit currently being scanned.
    always_comb begin
        w_nibble = 4'h0;
        case (r_digit)
            2'd0:    w_nibble = r_active[3:0];
            2'd1:    w_nibble = r_active[7:4];
            2'd2:    w_nibble = r_active[11:8];
            2'd3:    w_nibble = r_active[15:12];
            default: w_nibble = 4'h0;
        endcase
    end

    // A digit is a leading zero when it and every more-significant nibble are
    // zero; digit 0 always stays lit so a zero value still shows "0".
    always_comb begin
        w_lz_dark = 1'b0;
        case (r_digit)
            2'd0:    w_lz_dark = 1'b0;
            2'd1:    w_lz_dark = (r_active[15:4]  == 12'h000);
            2'd2:    w_lz_dark = (r_active[15:8]  == 8'h00);
            2'd3:    w_lz_dark = (r_active[15:12] == 4'h0);
            default: w_lz_dark = 1'b0;
        endcase
    end

    assign w_dark = blank_mask[r_digit] | (lzs & w_lz_dark);

    seg7_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Output registers: one cycle behind the scan state, dark digits drive
    // neither anode nor segments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= 4'b0000;
            r_leds       <= 7'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_dark ? 4'b0000 : an_onehot(r_digit);
            r_leds       <= w_dark ? 7'h00   : w_seg;
            r_frame_done <= w_boundary;
        end
    end

    assign leds       = r_leds;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        lzs;
    logic [3:0]  blank_mask;
    logic [6:0]  leds;
    logic [3:0]  an;
    logic        frame_done;

    seg7_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .lzs        (lzs),
        .blank_mask (blank_mask),
        .leds       (leds),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] leds;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int          m_div;
    int          m_digit;
    logic [15:0] m_shadow;
    logic [15:0] m_active;
    logic        m_pending;
    logic        last_fd;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div     = 0;
        m_digit   = 0;
        m_shadow  = 16'h0000;
        m_active  = 16'h0000;
        m_pending = 1'b0;
        sb_q.delete();
    endtask

    // One clock: push the expected outputs for the coming edge, advance the
    // model, then pop and compare against the DUT just after the edge.
    task automatic cycle();
        exp_t e;
        bit   dark;
        bit   tick;
        bit   bnd;
        dark = blank_mask[m_digit] ||
               (lzs && (m_digit >= 1) && ((m_active >> (4 * m_digit)) == 16'h0000));
        e.an   = dark ? 4'b0000 : 4'(1 << m_digit);
        e.leds = dark ? 7'h00 : seg_of(4'(m_active >> (4 * m_digit)));
        tick   = (m_div == CLK_DIV - 1);
        bnd    = tick && (m_digit == 3);
        e.fd   = bnd;
        sb_q.push_back(e);

        if (tick) begin
            m_div   = 0;
            m_digit = (m_digit + 1) % 4;
        end else begin
            m_div = m_div + 1;
        end
        if (load && bnd) begin
            m_active  = value;
            m_shadow  = value;
            m_pending = 1'b0;
        end else if (load) begin
            m_shadow  = value;
            m_pending = 1'b1;
        end else if (bnd && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_an",   16'(an),         16'(e.an));
        chk("sb_leds", 16'(leds),       16'(e.leds));
        chk("sb_fd",   16'(frame_done), 16'(e.fd));
        last_fd = frame_done;
    endtask

    // Run until a frame_done pulse is seen (bounded).
    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!last_fd && (k < 40));
        chk("frame_timeout", 16'(last_fd), 16'h0001);
    endtask

    // Check one whole frame against fixed expectations, starting on digit 0.
    task automatic check_frame(input logic [6:0] l0, input logic [6:0] l1,
                               input logic [6:0] l2, input logic [6:0] l3,
                               input logic [3:0] mask);
        logic [6:0] lv [4];
        int fds;
        int s;
        lv  = '{l0, l1, l2, l3};
        fds = 0;
        for (int k = 0; k < 4 * CLK_DIV; k++) begin
            cycle();
            s = k / CLK_DIV;
            chk("frame_an",   16'(an),   mask[s] ? 16'(1 << s) : 16'h0000);
            chk("frame_leds", 16'(leds), 16'(lv[s]));
            if (frame_done) fds++;
        end
        chk("frame_fd_count", 16'(fds), 16'h0001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = 1'b0; value = 16'h0000; lzs = 1'b0; blank_mask = 4'b0000;
        last_fd = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an",   16'(an),         16'h0000);
        chk("rst_leds", 16'(leds),       16'h0000);
        chk("rst_fd",   16'(frame_done), 16'h0000);
        rst = 1'b0;

        // 1: idle scan of zero, two frames
        check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b1111);
        check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b1111);

        // 2: mid-frame load appears only after the boundary
        repeat (5) cycle();
        value = 16'h1A2F; load = 1'b1; cycle(); load = 1'b0; value = 16'h0000;
        wait_frame();
        check_frame(7'h71, 7'h5B, 7'h77, 7'h06, 4'b1111);

        // 3: two loads in one frame, last wins
        repeat (3) cycle();
        value = 16'h1111; load = 1'b1; cycle(); load = 1'b0;
        repeat (3) cycle();
        value = 16'h2222; load = 1'b1; cycle(); load = 1'b0;
        wait_frame();
        check_frame(7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b1111);

        // 4: load exactly on the boundary edge with leading-zero suppression
        lzs = 1'b1;
        repeat (4 * CLK_DIV - 1) cycle();
        value = 16'h00C5; load = 1'b1; cycle(); load = 1'b0;
        chk("bnd_load_edge_fd", 16'(last_fd), 16'h0001);
        check_frame(7'h6D, 7'h39, 7'h00, 7'h00, 4'b0011);
        repeat (2) cycle();
        value = 16'h0000; load = 1'b1; cycle(); load = 1'b0;
        wait_frame();
        check_frame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0001);

        // 5: blank mask on digit 2
        lzs = 1'b0;
        value = 16'hFFFF; load = 1'b1; cycle(); load = 1'b0;
        wait_frame();
        blank_mask = 4'b0100;
        check_frame(7'h71, 7'h71, 7'h00, 7'h71, 4'b1011);
        blank_mask = 4'b0000;

        // 6: reset during the digit-2 slot with a load pending
        value = 16'h1234; load = 1'b1; cycle(); load = 1'b0;
        wait_frame();
        repeat (2 * CLK_DIV + 1) cycle();
        value = 16'h5678; load = 1'b1; cycle(); load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_an",   16'(an),         16'h0000);
        chk("async_rst_leds", 16'(leds),       16'h0000);
        chk("async_rst_fd",   16'(frame_done), 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        chk("held_rst_an", 16'(an), 16'h0000);
        rst = 1'b0;
        check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
